// File: rtl/fft_reorder_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_reorder_buf_pkg
//  Purpose  : Shared FFT definitions (frame size, sample width) plus the
//             reorder-buffer read-FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================

// Frame length exponent and packed complex sample width shared by FFT blocks.
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 4
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

package fft_reorder_buf_pkg;

  // Number of points in one FFT frame.
  localparam int FFT_POINTS = 1 << `TOTAL_STAGE;

  // Read-side sequencer states.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RUN  = 2'd1,
    R_DONE = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_reorder_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_reorder_buf_if
//  Purpose  : Write strobe bus from the bit-reverse stage and the valid/ready
//             sample stream towards the first butterfly stage.
//  Revision : 1.0  initial release
// ============================================================================
interface fft_reorder_buf_if #(
  parameter int N_STAGE = `TOTAL_STAGE,
  parameter int DW      = `CPLX_WIDTH
);
  logic               ien;
  logic [N_STAGE-1:0] iaddr;
  logic [DW-1:0]      idata;
  logic               ovalid;
  logic               oready;
  logic [N_STAGE-1:0] oaddr;
  logic [DW-1:0]      odata;
  logic               olast;

  // Environment side: produces writes, consumes the output stream.
  modport master (
    output ien, iaddr, idata, oready,
    input  ovalid, oaddr, odata, olast
  );

  // Buffer side.
  modport slave (
    input  ien, iaddr, idata, oready,
    output ovalid, oaddr, odata, olast
  );
endinterface
`default_nettype wire

// File: rtl/fft_reorder_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fft_reorder_ram
//  Purpose  : Simple dual-port RAM, one write port and one registered read
//             port with read enable. Kept separate so a vendor block RAM can
//             be dropped in.
//  Revision : 1.0  initial release
// ============================================================================
module fft_reorder_ram
  import fft_reorder_buf_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage array: plain write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read output register; cleared by reset so the stream data reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/fft_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fft_reorder_buf
//  Purpose  : Ping-pong frame buffer after the FFT bit-reverse stage. Frames
//             are written at bit-reversed indices and streamed out in natural
//             order over valid/ready.
//  Options  : FFT_REORDER_OVF_CNT_EN adds a 16-bit saturating dropped-write
//             counter output ovf_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module fft_reorder_buf
  import fft_reorder_buf_pkg::*;
#(
  parameter int N_STAGE = `TOTAL_STAGE,
  parameter int DW      = `CPLX_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_reorder_buf_if.slave   bus,
  output logic               ovf,
  input  logic               ovf_clr
`ifdef FFT_REORDER_OVF_CNT_EN
  ,
  output logic [15:0]        ovf_cnt
`endif
);
  localparam logic [N_STAGE-1:0] C_LAST_IDX = '1;

  logic               wr_bank_q;
  logic [N_STAGE-1:0] wr_cnt_q;
  logic [1:0]         bank_full_q;
  logic [1:0]         bank_full_d;
  logic               ovf_q;

  rd_state_e          state_q;
  logic               rd_bank_q;
  logic [N_STAGE-1:0] rd_idx_q;
  logic               ovalid_q;
  logic [N_STAGE-1:0] oaddr_q;
  logic               olast_q;

  logic w_wr_full;
  logic w_wr_acc;
  logic w_drop;
  logic w_wr_done;
  logic w_rd_en;
  logic w_rel;

  // Full flag is sampled before any same-cycle release, so a write to the
  // bank being freed this cycle is still dropped.
  assign w_wr_full = bank_full_q[wr_bank_q];
  assign w_wr_acc  = bus.ien && !w_wr_full;
  assign w_drop    = bus.ien && w_wr_full;
  assign w_wr_done = w_wr_acc && (wr_cnt_q == C_LAST_IDX);
  assign w_rd_en   = (state_q == R_RUN) && (!ovalid_q || bus.oready);
  assign w_rel     = (state_q == R_DONE) && ovalid_q && bus.oready && olast_q;

  // Bank ownership: writer fills a bank, reader frees it after olast is taken.
  always_comb begin
    bank_full_d = bank_full_q;
    if (w_wr_done) bank_full_d[wr_bank_q] = 1'b1;
    if (w_rel)     bank_full_d[rd_bank_q] = 1'b0;
  end

  // Write side: count accepted writes, hand the bank over after a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      bank_full_q <= 2'b00;
    end else begin
      bank_full_q <= bank_full_d;
      if (w_wr_acc) begin
        if (w_wr_done) begin
          wr_cnt_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_cnt_q  <= wr_cnt_q + N_STAGE'(1);
        end
      end
    end
  end

  // Sticky overflow flag; a drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (w_drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef FFT_REORDER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  // Saturating dropped-write count; a same-cycle clear restarts it at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else if (w_drop) begin
      if (ovf_clr)                  ovf_cnt_q <= 16'd1;
      else if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end else if (ovf_clr) begin
      ovf_cnt_q <= '0;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  // Read sequencer: issue reads in natural order, stream attributes are
  // registered alongside the RAM output and hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= R_IDLE;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      ovalid_q  <= 1'b0;
      oaddr_q   <= '0;
      olast_q   <= 1'b0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (bank_full_q[rd_bank_q]) begin
            rd_idx_q <= '0;
            state_q  <= R_RUN;
          end
        end
        R_RUN: begin
          if (w_rd_en) begin
            ovalid_q <= 1'b1;
            oaddr_q  <= rd_idx_q;
            olast_q  <= (rd_idx_q == C_LAST_IDX);
            rd_idx_q <= rd_idx_q + N_STAGE'(1);
            if (rd_idx_q == C_LAST_IDX) state_q <= R_DONE;
          end
        end
        R_DONE: begin
          if (w_rel) begin
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
            rd_bank_q <= ~rd_bank_q;
            state_q   <= R_IDLE;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  fft_reorder_ram #(
    .AW (N_STAGE + 1),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (w_wr_acc),
    .waddr_i ({wr_bank_q, bus.iaddr}),
    .wdata_i (bus.idata),
    .re_i    (w_rd_en),
    .raddr_i ({rd_bank_q, rd_idx_q}),
    .rdata_o (bus.odata)
  );

  assign bus.ovalid = ovalid_q;
  assign bus.oaddr  = oaddr_q;
  assign bus.olast  = olast_q;
  assign ovf        = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_fft_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_reorder_buf
//  Purpose  : Directed self-checking bench for fft_reorder_buf (16 points,
//             32-bit samples).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_reorder_buf;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk;
  logic rst_n;
  logic ovf;
  logic ovf_clr;
`ifdef FFT_REORDER_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  fft_reorder_buf_if #(.N_STAGE(4), .DW(32)) bus ();

  fft_reorder_buf #(.N_STAGE(4), .DW(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`ifdef FFT_REORDER_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected natural-order beats of a frame whose i-th write carried base+i.
  task automatic push_frame(input logic [31:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      logic [3:0] jj;
      jj = j[3:0];
      exp_q.push_back('{a: jj, d: base + {28'd0, bitrev4(jj)}, l: (jj == 4'hF)});
    end
  endtask

  task automatic write_frame(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      bus.ien   = 1'b1;
      bus.iaddr = bitrev4(i[3:0]);
      bus.idata = base + i;
      tick();
    end
    bus.ien = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
    tick();
  endtask

  // Stream monitor: every valid beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.ovalid) begin
      chk("beat_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chk("oaddr", bus.oaddr, exp_q[0].a);
        chk("odata", bus.odata, exp_q[0].d);
        chk("olast", bus.olast, exp_q[0].l);
        if (bus.oready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    ovf_clr   = 1'b0;
    bus.ien   = 1'b0;
    bus.iaddr = '0;
    bus.idata = '0;
    bus.oready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_ovalid", bus.ovalid, 0);
    chk("rst_odata",  bus.odata,  0);
    chk("rst_oaddr",  bus.oaddr,  0);
    chk("rst_olast",  bus.olast,  0);
    chk("rst_ovf",    ovf,        0);
`ifdef FFT_REORDER_OVF_CNT_EN
    chk("rst_ovf_cnt", ovf_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Bit-reversed write, natural-order read, latency and contiguity
    bus.oready = 1'b1;
    push_frame(32'd0, 16);
    write_frame(32'd0);
    chk("lat_edge0", bus.ovalid, 0);
    tick();
    chk("lat_edge1", bus.ovalid, 0);
    tick();
    chk("lat_edge2", bus.ovalid, 1);
    chk("lat_first_addr", bus.oaddr, 0);
    for (int k = 0; k < 16; k++) begin
      chk("contiguous", bus.ovalid, 1);
      tick();
    end
    chk("frame_end_ovalid", bus.ovalid, 0);
    chk("frame1_drained", exp_q.size(), 0);

    // Backpressure with oready pattern 1,0,0,1
    bus.oready = 1'b0;
    push_frame(32'd100, 16);
    write_frame(32'd100);
    n = 0;
    while ((exp_q.size() != 0) && n < 120) begin
      bus.oready = ((n % 4) == 0) || ((n % 4) == 3);
      tick();
      n++;
    end
    chk("bp_drained", exp_q.size(), 0);
    bus.oready = 1'b1;
    tick();

    // Ping-pong: three frames
    push_frame(32'd200, 16);
    push_frame(32'd300, 16);
    push_frame(32'd400, 16);
    write_frame(32'd200);
    repeat (2) tick();
    write_frame(32'd300);
    repeat (2) tick();
    write_frame(32'd400);
    wait_empty("pp_drained", 100);
    chk("pp_ovf", ovf, 0);

    // Overflow: both banks fill, eight writes dropped
    bus.oready = 1'b0;
    push_frame(32'd500, 16);
    push_frame(32'd600, 16);
    write_frame(32'd500);
    write_frame(32'd600);
    for (int i = 0; i < 8; i++) begin
      bus.ien   = 1'b1;
      bus.iaddr = i[3:0];
      bus.idata = 32'hBAD0 + i;
      tick();
    end
    bus.ien = 1'b0;
    chk("ovf_set", ovf, 1);
`ifdef FFT_REORDER_OVF_CNT_EN
    chk("ovf_cnt8", ovf_cnt, 8);
`endif
    bus.oready = 1'b1;
    wait_empty("ovf_drained", 100);
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
`ifdef FFT_REORDER_OVF_CNT_EN
    chk("ovf_cnt_cleared", ovf_cnt, 0);
`endif

    // Reset during beat index 4
    push_frame(32'd700, 4);
    write_frame(32'd700);
    n = 0;
    while (!(bus.ovalid && bus.oaddr == 4'd4) && n < 40) begin
      tick();
      n++;
    end
    chk("mid_beat_found", (n < 40), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", bus.ovalid, 0);
    chk("mid_rst_odata",  bus.odata,  0);
    chk("mid_rst_olast",  bus.olast,  0);
    chk("mid_rst_seen4",  exp_q.size(), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    push_frame(32'd800, 16);
    write_frame(32'd800);
    wait_empty("post_rst_drained", 60);
    chk("post_rst_ovf", ovf, 0);

    // Same-cycle release and write into the bank being released
    bus.oready = 1'b0;
    push_frame(32'd900, 16);
    push_frame(32'd1000, 16);
    push_frame(32'd1100, 16);
    write_frame(32'd900);
    write_frame(32'd1000);
    chk("sc_pre_ovf", ovf, 0);
    bus.oready = 1'b1;
    n = 0;
    while (!(bus.ovalid && bus.olast) && n < 60) begin
      tick();
      n++;
    end
    chk("sc_olast_found", (n < 60), 1);
    bus.ien   = 1'b1;
    bus.iaddr = 4'd0;
    bus.idata = 32'hDEAD;
    ovf_clr   = 1'b1;
    tick();
    bus.ien = 1'b0;
    ovf_clr = 1'b0;
    chk("sc_drop_ovf", ovf, 1);
`ifdef FFT_REORDER_OVF_CNT_EN
    chk("sc_drop_cnt", ovf_cnt, 1);
`endif
    write_frame(32'd1100);
    wait_empty("sc_drained", 120);
    chk("sc_final_ovalid", bus.ovalid, 0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
